mcb_port_emulator: RTL

Single-clock behavioural responder for one Spartan-6 MCB user port (command, write-data and read-data FIFO interface) backed by on-chip block RAM. Drop-in target for `ddrPort0Controller`, `ddrPort1Controller` and `colorModule` during simulation and DDR2-less bring-up, sitting where `videoRam` normally connects. Accepts the same command and FIFO handshakes, executes bursts against an internal word array, and reports FIFO status with MCB-compatible semantics.

---
 rtl/mcb_port_if.sv | 35 +++
 rtl/mcb_port_emulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_port_if.sv
// Signal bundle for one MCB user port: command, write-data and read-data FIFO
// handshakes plus calibration status.
interface mcb_port_if;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty;
  logic        cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        calib_done;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    input  cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun,
           rd_data, rd_full, rd_empty, rd_count, calib_done
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    output cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun,
           rd_data, rd_full, rd_empty, rd_count, calib_done
  );
endinterface

// File: rtl/mcb_port_emulator.sv
// Behavioural Spartan-6 MCB user-port responder: command/write/read FIFOs in
// front of an on-chip word array, with MCB-compatible registered status.
module mcb_port_emulator #(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned CALIB_CYCLES = 16
) (
  input  logic      clk,
  input  logic      SYS_RESETn,
  mcb_port_if.slave port
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned FPW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned CMD_DEPTH = 4;
  localparam int unsigned CPW       = 2;
  localparam int unsigned CCW       = 3;
  localparam int unsigned CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned BT_W      = 7;

  localparam logic [1:0] S_CALIB = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  typedef struct packed {
    logic          is_wr;
    logic          is_rd;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;

  logic [1:0]       state_q, state_d;
  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
  logic             calib_done_q, calib_done_d;
  logic [CPW-1:0]   cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CCW-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic             cmd_empty_q, cmd_full_q;
  logic [FPW-1:0]   wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
  logic [FPW-1:0]   rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_empty_q, wr_full_q, rd_empty_q, rd_full_q;
  logic             wr_underrun_q, wr_underrun_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [BT_W-1:0]  beats_q, beats_d;
  logic             rd_vld_q;

  cmd_t        cmd_mem [CMD_DEPTH];
  logic [35:0] wr_mem  [FIFO_DEPTH];
  logic [31:0] rd_mem  [FIFO_DEPTH];
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] bram_q;

  logic             cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop, rd_issue;
  cmd_t             cmd_in, cmd_head;
  logic [35:0]      wr_head;
  logic [CNT_W:0]   rd_pending;
  logic [CNT_W-1:0] rd_left;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{port.cmd_instr[1], port.cmd_byte_addr[1:0],
                              port.cmd_byte_addr[29:AW+2]};

  assign cmd_in.is_wr = ~port.cmd_instr[2] & ~port.cmd_instr[0];
  assign cmd_in.is_rd = ~port.cmd_instr[2] &  port.cmd_instr[0];
  assign cmd_in.bl    = port.cmd_bl;
  assign cmd_in.addr  = port.cmd_byte_addr[AW+1:2];

  // Next-state, burst sequencing and FIFO bookkeeping
  always_comb begin
    state_d       = state_q;
    cal_cnt_d     = cal_cnt_q;
    calib_done_d  = calib_done_q;
    addr_d        = addr_q;
    beats_d       = beats_q;
    wr_underrun_d = 1'b0;
    cmd_pop       = 1'b0;
    wr_pop        = 1'b0;
    rd_issue      = 1'b0;
    cmd_head      = cmd_mem[cmd_rp_q];
    wr_head       = wr_mem[wr_rp_q];
    rd_pending    = (CNT_W+1)'(rd_cnt_q) + (CNT_W+1)'(rd_vld_q);

    case (state_q)
      S_CALIB: begin
        if (cal_cnt_q == CAL_W'(CALIB_CYCLES)) begin
          state_d      = S_IDLE;
          calib_done_d = 1'b1;
        end else begin
          cal_cnt_d = cal_cnt_q + CAL_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_cnt_q != '0) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_head.addr;
          beats_d = BT_W'(cmd_head.bl) + BT_W'(1);
          if (cmd_head.is_wr)      state_d = S_WRITE;
          else if (cmd_head.is_rd) state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (wr_cnt_q != '0) begin
          wr_pop  = 1'b1;
          addr_d  = addr_q + AW'(1);
          beats_d = beats_q - BT_W'(1);
          if (beats_q == BT_W'(1)) state_d = S_IDLE;
        end else begin
          wr_underrun_d = 1'b1;
        end
      end
      S_READ: begin
        // Only issue when the landing slot is guaranteed free
        if (rd_pending < (CNT_W+1)'(FIFO_DEPTH)) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + AW'(1);
          beats_d  = beats_q - BT_W'(1);
          if (beats_q == BT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_CALIB;
    endcase

    cmd_push  = port.cmd_en & ~cmd_full_q & calib_done_q;
    wr_push   = port.wr_en & ~wr_full_q;
    rd_push   = rd_vld_q;
    rd_pop    = port.rd_en & ~rd_empty_q;

    cmd_wp_d  = cmd_wp_q + CPW'(cmd_push);
    cmd_rp_d  = cmd_rp_q + CPW'(cmd_pop);
    cmd_cnt_d = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
    wr_wp_d   = wr_wp_q + FPW'(wr_push);
    wr_rp_d   = wr_rp_q + FPW'(wr_pop);
    wr_cnt_d  = wr_cnt_q + CNT_W'(wr_push) - CNT_W'(wr_pop);
    rd_wp_d   = rd_wp_q + FPW'(rd_push);
    rd_rp_d   = rd_rp_q + FPW'(rd_pop);
    rd_cnt_d  = rd_cnt_q + CNT_W'(rd_push) - CNT_W'(rd_pop);

    // First-word-fall-through head; holds its value when the FIFO drains
    rd_left   = rd_cnt_q - CNT_W'(rd_pop);
    rd_data_d = rd_data_q;
    if (rd_left != '0)  rd_data_d = rd_mem[rd_rp_d];
    else if (rd_push)   rd_data_d = bram_q;
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      state_q       <= S_CALIB;
      cal_cnt_q     <= '0;
      calib_done_q  <= 1'b0;
      cmd_wp_q      <= '0;
      cmd_rp_q      <= '0;
      cmd_cnt_q     <= '0;
      cmd_empty_q   <= 1'b1;
      cmd_full_q    <= 1'b0;
      wr_wp_q       <= '0;
      wr_rp_q       <= '0;
      wr_cnt_q      <= '0;
      wr_empty_q    <= 1'b1;
      wr_full_q     <= 1'b0;
      rd_wp_q       <= '0;
      rd_rp_q       <= '0;
      rd_cnt_q      <= '0;
      rd_empty_q    <= 1'b1;
      rd_full_q     <= 1'b0;
      wr_underrun_q <= 1'b0;
      rd_data_q     <= '0;
      addr_q        <= '0;
      beats_q       <= '0;
      rd_vld_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cal_cnt_q     <= cal_cnt_d;
      calib_done_q  <= calib_done_d;
      cmd_wp_q      <= cmd_wp_d;
      cmd_rp_q      <= cmd_rp_d;
      cmd_cnt_q     <= cmd_cnt_d;
      cmd_empty_q   <= (cmd_cnt_d == '0);
      cmd_full_q    <= (cmd_cnt_d == CCW'(CMD_DEPTH));
      wr_wp_q       <= wr_wp_d;
      wr_rp_q       <= wr_rp_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_empty_q    <= (wr_cnt_d == '0);
      wr_full_q     <= (wr_cnt_d == CNT_W'(FIFO_DEPTH));
      rd_wp_q       <= rd_wp_d;
      rd_rp_q       <= rd_rp_d;
      rd_cnt_q      <= rd_cnt_d;
      rd_empty_q    <= (rd_cnt_d == '0);
      rd_full_q     <= (rd_cnt_d == CNT_W'(FIFO_DEPTH));
      wr_underrun_q <= wr_underrun_d;
      rd_data_q     <= rd_data_d;
      addr_q        <= addr_d;
      beats_q       <= beats_d;
      rd_vld_q      <= rd_issue;
    end
  end

  // FIFO storage, deliberately unreset
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= cmd_in;
    if (wr_push)  wr_mem[wr_wp_q]   <= {port.wr_mask, port.wr_data};
    if (rd_push)  rd_mem[rd_wp_q]   <= bram_q;
  end

  // Backing store: byte-masked write port, registered read port
  always_ff @(posedge clk) begin
    if (wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head[32+b]) mem[addr_q][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
    if (rd_issue) bram_q <= mem[addr_q];
  end

  assign port.cmd_empty   = cmd_empty_q;
  assign port.cmd_full    = cmd_full_q;
  assign port.wr_full     = wr_full_q;
  assign port.wr_empty    = wr_empty_q;
  assign port.wr_count    = wr_cnt_q;
  assign port.wr_underrun = wr_underrun_q;
  assign port.rd_data     = rd_data_q;
  assign port.rd_full     = rd_full_q;
  assign port.rd_empty    = rd_empty_q;
  assign port.rd_count    = rd_cnt_q;
  assign port.calib_done  = calib_done_q;

endmodule
